if_prefetch_ctrl: RTL
=====================

Name: if_prefetch_ctrl

Overview:
- Upstream neighbour of the instruction-fetch capture stage.
- Generates sequential word-aligned fetch addresses and drives the instruction-memory req/gnt/rvalid protocol.
- Buffers returned words, with their address and error flag, in a small FIFO.
- Presents the FIFO head to the fetch stage through a valid/ready handshake.
- On a branch redirect it flushes buffered words and silently discards responses still in flight.

Parameters:
- DEPTH, 4, FIFO entries; also the credit limit on buffered plus in-flight words (>=2).
- MAX_OUTST, 2, maximum accepted-but-unanswered memory requests (1..DEPTH).
- BOOT_ADDR, 32'h0000_0080, first fetch address after reset; must be word-aligned.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- fetch_enable_i  in  1  permits issuing new requests.
- branch_i  in  1  redirect strobe, one cycle.
- branch_addr_i  in  32  redirect target; bits [1:0] are forced to 0.
- instr_req_o  out  1  memory request.
- instr_addr_o  out  32  request address.
- instr_gnt_i  in  1  request accepted.
- instr_rvalid_i  in  1  response valid; responses return in order.
- instr_rdata_i  in  32  response data.
- instr_err_i  in  1  response bus error.
- valid_o  out  1  FIFO head valid.
- ready_i  in  1  downstream accepts the head.
- rdata_o  out  32  head instruction word.
- addr_o  out  32  head address.
- err_o  out  1  head error flag.

Behaviour:
- Reset state (rst_i high, asynchronous): fetch_addr=BOOT_ADDR, resp_addr=BOOT_ADDR, outst=0, discard=0, FIFO empty. Outputs: instr_req_o=0, valid_o=0, rdata_o=0, addr_o=0, err_o=0. instr_addr_o=BOOT_ADDR.
- Credit: occ = FIFO occupancy, live = outst - discard. Request condition: instr_req_o = fetch_enable_i & !branch_i & (occ+live < DEPTH) & (outst < MAX_OUTST).
- Stability: once instr_req_o rises, it and instr_addr_o hold until instr_gnt_i. Exception: a branch cycle forces req low and lets the address change. Deasserting fetch_enable_i does not drop a pending request.
- Grant: on req & gnt, fetch_addr += 4 (wraps modulo 2^32) and outst += 1 in the same edge.
- Response: on instr_rvalid_i, outst -= 1.
  - If discard > 0: discard -= 1 and the data is dropped.
  - Otherwise push {resp_addr, rdata, err} and resp_addr += 4.
  - Simultaneous grant and rvalid leaves outst unchanged.
- Push into the FIFO never overflows; the credit rule guarantees it. A push while full is an assertion failure.
- Pop occurs on valid_o & ready_i. valid_o = !empty.
- Latency: no bypass. A word arriving on rvalid at edge N is visible at valid_o after N.
- Simultaneous push and pop is allowed at any occupancy, including full (pop frees the slot).
- Branch (takes priority over everything in that cycle):
  - FIFO is cleared and valid_o=0 next cycle.
  - fetch_addr = resp_addr = {branch_addr_i[31:2], 2'b00}.
  - discard = outst - instr_rvalid_i.
  - No grant can occur because req is low.
  - An rvalid in the branch cycle is dropped, not pushed.
  - A pop in the branch cycle is honoured by downstream but irrelevant, since the FIFO is cleared.
- Error responses are buffered normally. err_o simply accompanies the word; no retry is attempted.
- instr_gnt_i without req, or instr_rvalid_i with outst=0: ignored, assertion failure.
- Counter widths are $clog2(DEPTH+1).

Decomposition:
- Package if_pkg:
  - fetch_entry_t struct {addr[31:0], rdata[31:0], err}.
  - Constant INSTR_ALIGN_MASK = 32'hFFFF_FFFC.
  - Default BOOT_ADDR constant.
- Sub-module if_fetch_fifo:
  - Parameterised by DEPTH and the entry type.
  - Ports: push, pop, flush, full, empty, occupancy, head.
  - Circular pointers with an extra wrap bit; flush resets the pointers.
- The controller holds the credit logic, address counters and discard counter.

Test Plan:
- Boot stream: gnt=1 every cycle, rvalid one cycle after each gnt, ready_i=1. First requests go to 0x80, 0x84, 0x88. valid_o/addr_o deliver 0x80, 0x84 in order, with at most 2 outstanding.
- Backpressure: ready_i=0, DEPTH=4. Requests stop after occ+live=4; instr_req_o stays 0. Raise ready_i and the words pop in order, then requests resume at 0x90.
- Branch with 2 in flight: branch_i with target 0x1003 while outst=2. The next request address is 0x1000. The two stale rvalids are dropped; the first valid_o carries addr_o=0x1000.
- Branch coincident with rvalid: outst=2, rvalid=1 in the branch cycle. Require discard=1, exactly one more word dropped, and the FIFO empty afterwards.
- Error propagation: instr_err_i=1 on the response for 0x84. Require err_o=1 only with addr_o=0x84 and the stream continuing to 0x88.
- Async reset mid-burst: assert rst_i between edges with outst=2. Outputs clear immediately; after release the first request is BOOT_ADDR and late rvalids are flagged by the assertion.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction prefetch controller.
package if_pkg;

    localparam logic [31:0] INSTR_ALIGN_MASK  = 32'hFFFF_FFFC;
    localparam logic [31:0] DEFAULT_BOOT_ADDR = 32'h0000_0080;
    localparam logic [31:0] INSTR_STEP        = 32'd4;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] rdata;
        logic        err;
    } fetch_entry_t;

    typedef enum logic {
        REQ_IDLE,
        REQ_HOLD
    } req_state_t;

endpackage

// File: rtl/if_fetch_fifo.sv
// Circular FIFO holding fetched words; pointers carry a wrap bit so full/empty
// are distinguishable at any depth. Flush returns both pointers to zero.
module if_fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter type entry_t = logic [64:0],
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  entry_t           din,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] occupancy,
    output entry_t           head
);

    logic [PTR_W-1:0] wr_idx;
    logic [PTR_W-1:0] rd_idx;
    logic             wr_wrap;
    logic             rd_wrap;
    logic             push_ok;
    logic             pop_ok;
    entry_t           mem [DEPTH];

    assign empty   = (wr_idx == rd_idx) && (wr_wrap == rd_wrap);
    assign full    = (wr_idx == rd_idx) && (wr_wrap != rd_wrap);
    assign pop_ok  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push at full is still legal.
    assign push_ok = push & (~full | pop_ok);
    assign head    = mem[rd_idx];

    always_comb begin
        if (wr_wrap == rd_wrap) begin
            occupancy = CNT_W'(wr_idx) - CNT_W'(rd_idx);
        end else begin
            occupancy = CNT_W'(DEPTH) - CNT_W'(rd_idx) + CNT_W'(wr_idx);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_idx  <= '0;
            rd_idx  <= '0;
            wr_wrap <= 1'b0;
            rd_wrap <= 1'b0;
        end else if (flush) begin
            wr_idx  <= '0;
            rd_idx  <= '0;
            wr_wrap <= 1'b0;
            rd_wrap <= 1'b0;
        end else begin
            if (push_ok) begin
                if (wr_idx == PTR_W'(DEPTH - 1)) begin
                    wr_idx  <= '0;
                    wr_wrap <= ~wr_wrap;
                end else begin
                    wr_idx <= wr_idx + PTR_W'(1);
                end
            end
            if (pop_ok) begin
                if (rd_idx == PTR_W'(DEPTH - 1)) begin
                    rd_idx  <= '0;
                    rd_wrap <= ~rd_wrap;
                end else begin
                    rd_idx <= rd_idx + PTR_W'(1);
                end
            end
        end
    end

    // Storage array: no reset, entries are only visible through valid pointers.
    always_ff @(posedge clk_i) begin
        if (push_ok && !flush) begin
            mem[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/if_prefetch_ctrl.sv
// Instruction prefetcher: issues sequential word fetches under a credit limit,
// buffers in-order responses and drops stale responses after a redirect.
module if_prefetch_ctrl
    import if_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned MAX_OUTST = 2,
    parameter logic [31:0] BOOT_ADDR = DEFAULT_BOOT_ADDR
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_enable_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] rdata_o,
    output logic [31:0] addr_o,
    output logic        err_o
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [31:0]      fetch_addr;
    logic [31:0]      resp_addr;
    logic [31:0]      branch_target;
    logic [CNT_W-1:0] outst;
    logic [CNT_W-1:0] discard;
    logic [CNT_W-1:0] live;
    logic [CNT_W-1:0] occ;
    logic             credit_ok;
    logic             req_c;
    logic             gnt_acc;
    logic             rv_acc;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;
    req_state_t       req_state_q;
    req_state_t       req_state_d;

    assign live          = outst - discard;
    assign credit_ok     = ((SUM_W'(occ) + SUM_W'(live)) < SUM_W'(DEPTH))
                           && (outst < CNT_W'(MAX_OUTST));
    assign branch_target = branch_addr_i & INSTR_ALIGN_MASK;

    // Request FSM: once raised, the request is held until granted or redirected.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_state_q <= REQ_IDLE;
        end else begin
            req_state_q <= req_state_d;
        end
    end

    always_comb begin
        req_state_d = REQ_IDLE;
        req_c       = 1'b0;
        unique case (req_state_q)
            REQ_IDLE: req_c = fetch_enable_i & credit_ok;
            REQ_HOLD: req_c = 1'b1;
            default:  req_c = 1'b0;
        endcase
        if (branch_i) begin
            req_c = 1'b0;
        end
        if (req_c && !instr_gnt_i) begin
            req_state_d = REQ_HOLD;
        end
    end

    assign instr_req_o  = req_c & ~rst_i;
    assign instr_addr_o = fetch_addr;

    assign gnt_acc    = instr_req_o & instr_gnt_i;
    assign rv_acc     = instr_rvalid_i & (outst != '0);
    assign push       = rv_acc & (discard == '0) & ~branch_i;
    assign pop        = valid_o & ready_i;
    assign push_entry = {resp_addr, instr_rdata_i, instr_err_i};

    // Address, outstanding and discard counters; a redirect overrides all.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_addr <= BOOT_ADDR;
            resp_addr  <= BOOT_ADDR;
            outst      <= '0;
            discard    <= '0;
        end else if (branch_i) begin
            fetch_addr <= branch_target;
            resp_addr  <= branch_target;
            outst      <= outst - CNT_W'(rv_acc);
            discard    <= outst - CNT_W'(rv_acc);
        end else begin
            if (gnt_acc) begin
                fetch_addr <= fetch_addr + INSTR_STEP;
            end
            outst <= outst + CNT_W'(gnt_acc) - CNT_W'(rv_acc);
            if (rv_acc) begin
                if (discard != '0) begin
                    discard <= discard - CNT_W'(1);
                end else begin
                    resp_addr <= resp_addr + INSTR_STEP;
                end
            end
        end
    end

    if_fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (fetch_entry_t)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (push),
        .pop       (pop),
        .flush     (branch_i),
        .din       (push_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .occupancy (occ),
        .head      (head)
    );

    assign valid_o = ~fifo_empty;
    assign rdata_o = fifo_empty ? 32'h0 : head.rdata;
    assign addr_o  = fifo_empty ? 32'h0 : head.addr;
    assign err_o   = fifo_empty ? 1'b0  : head.err;

    // Protocol checks: the credit rule must prevent overflow; the memory side
    // must never grant an absent request nor answer an unissued one.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        (push && fifo_full) |-> pop);
    a_gnt_has_req: assert property (@(posedge clk_i) disable iff (rst_i)
        instr_gnt_i |-> instr_req_o);
    a_rvalid_outst: assert property (@(posedge clk_i) disable iff (rst_i)
        instr_rvalid_i |-> (outst != '0));

endmodule
